// File: rtl/apb_burst_pkg.sv
// apb_burst_pkg: shared constants and types for the APB-to-byte-burst bridge.
//   - APB data/address widths
//   - register offsets in the upper half of the APB address space (paddr[8]=1)
//   - CTRL and STATUS bit positions
//   - bridge FSM state encoding
package apb_burst_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] ADDR_LEN    = 9'h100;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 9'h101;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 9'h102;
  localparam logic [ADDR_W-1:0] ADDR_RX_CNT = 9'h103;

  localparam int CTRL_TX_BIT        = 0;
  localparam int CTRL_RX_BIT        = 1;
  localparam int STATUS_IDLE_BIT    = 0;
  localparam int STATUS_RX_DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2
  } state_e;

endpackage

// File: rtl/apb_burst_modport_if.sv
// apb_burst_modport_if: bundles the APB slave port and the byte-burst stream
// port of the bridge.
//   slave  modport: the bridge's view (APB request/burst peer inputs in,
//                   read data, error, status and TX stream out)
//   master modport: the view of whoever drives the APB bus and the burst peer
interface apb_burst_modport_if;
  import apb_burst_pkg::*;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              plsverr;
  logic              apb_rd_done;
  logic              idle;
  logic              burst_valid;
  logic              burst_ready;
  logic [DATA_W-1:0] data_burst_in;
  logic              burst_last;
  logic [DATA_W-1:0] data_burst_out;
  logic [DATA_W-1:0] db_length;
  logic              last;
  logic              db_ready;
  logic              db_valid;

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    input  burst_valid, burst_ready, data_burst_in, burst_last,
    output prdata, plsverr, apb_rd_done, idle,
    output data_burst_out, db_length, last, db_ready, db_valid
  );

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    output burst_valid, burst_ready, data_burst_in, burst_last,
    input  prdata, plsverr, apb_rd_done, idle,
    input  data_burst_out, db_length, last, db_ready, db_valid
  );

endinterface

// File: rtl/apb_burst_buf.sv
// apb_burst_buf: DEPTH x 8 byte buffer, no reset on contents.
//   clk          rising-edge clock for the write port
//   we/waddr/wdata  single synchronous write port
//   raddr/rdata     asynchronous read port
module apb_burst_buf
  import apb_burst_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; the bridge guarantees only one writer is active at a time.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_burst_modport.sv
// apb_burst_modport: APB slave that fills/reads a byte buffer and runs TX or
// RX byte bursts on a valid/ready stream.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    apb_burst_modport_if.slave: APB (paddr/psel/penable/pwrite/pwdata,
//          prdata/plsverr/apb_rd_done), status (idle, db_length), TX stream
//          (db_valid/burst_ready/data_burst_out/last), RX stream
//          (burst_valid/db_ready/data_burst_in/burst_last)
// Optional macro APB_BURST_ERR_EN: when defined, illegal accesses raise
// plsverr; otherwise plsverr stays 0 but illegal accesses are still ignored.
module apb_burst_modport
  import apb_burst_pkg::*;
#(
  parameter int BUF_DEPTH = 256
) (
  input logic clk,
  input logic rst_n,
  apb_burst_modport_if.slave bus
);

  localparam int IDX_W = $clog2(BUF_DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        rx_cnt_q, rx_cnt_d;
  logic              rx_done_q, rx_done_d;
  logic              idle_q, idle_d;
  logic              db_valid_q, db_valid_d;
  logic              db_ready_q, db_ready_d;
  logic              last_q, last_d;

  logic              access, is_buf, buf_oob, unmapped, busy_hit, bad_ctrl, ro_write;
  logic              illegal, wr_ok, apb_err, rx_beat;
  logic [DATA_W-1:0] rd_data, status;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr, buf_raddr;
  logic [DATA_W-1:0] buf_wdata, buf_rdata;

  // Buffer indices beyond a shallow buffer are unmapped; a 256-byte buffer
  // covers the whole lower half of the address space.
  if (BUF_DEPTH < 256) begin : g_oob
    assign buf_oob = (bus.paddr[7:IDX_W] != '0);
  end else begin : g_full
    assign buf_oob = 1'b0;
  end

  // Access decode: everything that makes the current APB access illegal.
  // Buffer, LEN and CTRL are locked while a burst owns the buffer/index.
  always_comb begin
    access   = bus.psel && bus.penable;
    is_buf   = !bus.paddr[8];
    unmapped = (bus.paddr[8] && (bus.paddr[7:0] > 8'h03)) || (is_buf && buf_oob);
    busy_hit = !idle_q && (is_buf || bus.paddr == ADDR_LEN || bus.paddr == ADDR_CTRL);
    bad_ctrl = bus.pwrite && (bus.paddr == ADDR_CTRL) &&
               ((bus.pwdata[CTRL_TX_BIT] && bus.pwdata[CTRL_RX_BIT]) ||
                (bus.pwdata[CTRL_TX_BIT] && len_q == 8'd0));
    ro_write = bus.pwrite && (bus.paddr == ADDR_STATUS || bus.paddr == ADDR_RX_CNT);
    illegal  = unmapped || busy_hit || bad_ctrl || ro_write;
    wr_ok    = access && bus.pwrite && !illegal;
  end

  // Read data mux; illegal reads and non-access cycles return 0.
  always_comb begin
    status                     = '0;
    status[STATUS_IDLE_BIT]    = idle_q;
    status[STATUS_RX_DONE_BIT] = rx_done_q;
    rd_data                    = '0;
    if (access && !bus.pwrite && !illegal) begin
      if (is_buf) begin
        rd_data = buf_rdata;
      end else begin
        case (bus.paddr)
          ADDR_LEN:    rd_data = len_q;
          ADDR_STATUS: rd_data = status;
          ADDR_RX_CNT: rd_data = rx_cnt_q;
          default:     rd_data = '0;
        endcase
      end
    end
  end

  // Next-state logic for the FSM and its registered outputs. The outputs are
  // derived from the next state so they line up with the state register.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    rx_cnt_d  = rx_cnt_q;
    rx_done_d = rx_done_q;
    rx_beat   = 1'b0;
    if (wr_ok && bus.paddr == ADDR_LEN) len_d = bus.pwdata;
    case (state_q)
      IDLE: begin
        if (wr_ok && bus.paddr == ADDR_CTRL) begin
          if (bus.pwdata[CTRL_TX_BIT]) begin
            state_d   = TX;
            idx_d     = 8'd0;
            rx_done_d = 1'b0;
          end else if (bus.pwdata[CTRL_RX_BIT]) begin
            state_d   = RX;
            idx_d     = 8'd0;
            rx_done_d = 1'b0;
          end
        end
      end
      TX: begin
        if (db_valid_q && bus.burst_ready) begin
          idx_d = idx_q + 8'd1;
          if (last_q) state_d = IDLE;
        end
      end
      RX: begin
        if (bus.burst_valid && db_ready_q) begin
          rx_beat = 1'b1;
          idx_d   = idx_q + 8'd1;
          // A completely full 256-byte capture wraps RX_CNT to 0.
          if (bus.burst_last || idx_q == 8'(BUF_DEPTH - 1)) begin
            rx_cnt_d  = idx_q + 8'd1;
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    idle_d     = (state_d == IDLE);
    db_valid_d = (state_d == TX);
    db_ready_d = (state_d == RX);
    last_d     = (state_d == TX) && (idx_d == len_q - 8'd1);
  end

  // State and control registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      rx_cnt_q   <= 8'd0;
      rx_done_q  <= 1'b0;
      idle_q     <= 1'b1;
      db_valid_q <= 1'b0;
      db_ready_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_done_q  <= rx_done_d;
      idle_q     <= idle_d;
      db_valid_q <= db_valid_d;
      db_ready_q <= db_ready_d;
      last_q     <= last_d;
    end
  end

  // APB buffer writes are illegal during a burst, so RX and APB never collide.
  assign buf_we    = rx_beat || (wr_ok && is_buf);
  assign buf_waddr = rx_beat ? idx_q[IDX_W-1:0] : bus.paddr[IDX_W-1:0];
  assign buf_wdata = rx_beat ? bus.data_burst_in : bus.pwdata;
  assign buf_raddr = (state_q == TX) ? idx_q[IDX_W-1:0] : bus.paddr[IDX_W-1:0];

  apb_burst_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

`ifdef APB_BURST_ERR_EN
  assign apb_err = access && illegal;
`else
  assign apb_err = 1'b0;
`endif

  assign bus.plsverr        = apb_err;
  assign bus.apb_rd_done    = access && !bus.pwrite && !apb_err;
  assign bus.prdata         = rd_data;
  assign bus.idle           = idle_q;
  assign bus.db_valid       = db_valid_q;
  assign bus.db_ready       = db_ready_q;
  assign bus.last           = last_q;
  assign bus.db_length      = len_q;
  assign bus.data_burst_out = db_valid_q ? buf_rdata : '0;

endmodule

// File: tb/tb_apb_burst_modport.sv
// tb_apb_burst_modport: scoreboard bench for apb_burst_modport. Stimulus
// pushes expected APB responses and TX beats into queues; a monitor pops and
// compares whenever the DUT completes an APB access phase or a TX beat.
// Honours APB_BURST_ERR_EN the same way the design does.
module tb_apb_burst_modport;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_burst_modport_if bus();

  apb_burst_modport #(.BUF_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef APB_BURST_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct { logic [7:0] rdata; logic err; logic done; } apb_exp_t;
  typedef struct { logic [7:0] data; logic last; } beat_exp_t;

  apb_exp_t  apb_q[$];
  beat_exp_t beat_q[$];
  logic [7:0] rx_bytes[$];

  // Reference model state
  logic [7:0] m_buf [256];
  logic [7:0] m_len, m_rx_cnt;
  logic       m_rx_done, m_busy;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name, input int left);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: %0d items outstanding, expected 0", name, left);
  endtask

  // Address-map legality rules of the bridge, applied to the model state.
  function automatic bit is_illegal(input bit wr, input logic [8:0] addr, input logic [7:0] wdata);
    if (addr > 9'h103) return 1'b1;
    if (m_busy && addr <= 9'h101) return 1'b1;
    if (wr && addr == 9'h101 && wdata[0] && wdata[1]) return 1'b1;
    if (wr && addr == 9'h101 && wdata[0] && m_len == 8'd0) return 1'b1;
    if (wr && (addr == 9'h102 || addr == 9'h103)) return 1'b1;
    return 1'b0;
  endfunction

  // One APB transfer (setup + access phase) with its expected response.
  task automatic applyStimulus(input bit wr, input logic [8:0] addr, input logic [7:0] wdata);
    apb_exp_t e;
    bit bad;
    bad     = is_illegal(wr, addr, wdata);
    e.rdata = 8'h00;
    if (!wr && !bad) begin
      if (addr < 9'h100)       e.rdata = m_buf[addr[7:0]];
      else if (addr == 9'h100) e.rdata = m_len;
      else if (addr == 9'h102) e.rdata = {6'd0, m_rx_done, !m_busy};
      else if (addr == 9'h103) e.rdata = m_rx_cnt;
    end
    e.err  = ERR_EN && bad;
    e.done = !wr && !e.err;
    apb_q.push_back(e);
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    if (wr && !bad) begin
      if (addr < 9'h100) begin
        m_buf[addr[7:0]] = wdata;
      end else if (addr == 9'h100) begin
        m_len = wdata;
      end else if (addr == 9'h101 && wdata[0]) begin
        m_busy    = 1'b1;
        m_rx_done = 1'b0;
        for (int k = 0; k < int'(m_len); k++)
          beat_q.push_back('{m_buf[k], (k == int'(m_len) - 1)});
      end else if (addr == 9'h101 && wdata[1]) begin
        m_busy    = 1'b1;
        m_rx_done = 1'b0;
      end
    end
  endtask

  // Drain the expected TX beats with burst_ready either held or random.
  task automatic runTx(input bit random_ready);
    int guard;
    guard = 0;
    while (beat_q.size() != 0 && guard < 2000) begin
      bus.burst_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    bus.burst_ready = 1'b0;
    if (beat_q.size() != 0) begin
      reportTimeout("tx_timeout", beat_q.size());
      beat_q.delete();
    end
    m_busy = 1'b0;
    checkOutput("idle_after_tx", bus.idle, 1);
    checkOutput("db_valid_after_tx", bus.db_valid, 0);
  endtask

  // Feed rx_bytes with random valid gaps; burst_last marks the final byte.
  task automatic runRx();
    int  i, guard;
    logic v;
    i = 0;
    guard = 0;
    while (i < rx_bytes.size() && guard < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      bus.burst_valid   = v;
      bus.data_burst_in = v ? rx_bytes[i] : 8'($urandom);
      bus.burst_last    = (i == rx_bytes.size() - 1);
      if (v && bus.db_ready) begin
        m_buf[i] = rx_bytes[i];
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.burst_valid = 1'b0;
    bus.burst_last  = 1'b0;
    if (i < rx_bytes.size()) reportTimeout("rx_timeout", rx_bytes.size() - i);
    m_busy    = 1'b0;
    m_rx_done = 1'b1;
    m_rx_cnt  = 8'(rx_bytes.size());
    checkOutput("idle_after_rx", bus.idle, 1);
    checkOutput("db_ready_after_rx", bus.db_ready, 0);
  endtask

  // Monitor: compares every APB access phase and every TX beat transfer.
  initial begin : monitor
    apb_exp_t  ae;
    beat_exp_t be;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.psel && bus.penable) begin
          if (apb_q.size() == 0) begin
            reportTimeout("apb_unexpected_access", 0);
          end else begin
            ae = apb_q.pop_front();
            checkOutput("prdata", bus.prdata, ae.rdata);
            checkOutput("plsverr", bus.plsverr, ae.err);
            checkOutput("apb_rd_done", bus.apb_rd_done, ae.done);
          end
        end
        if (bus.db_valid && bus.burst_ready) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL tx_unexpected_beat: got data 0x%0h, expected no beat", bus.data_burst_out);
          end else begin
            be = beat_q.pop_front();
            checkOutput("tx_data", bus.data_burst_out, be.data);
            checkOutput("tx_last", bus.last, be.last);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int guard;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    bus.burst_valid = 1'b0; bus.burst_ready = 1'b0;
    bus.data_burst_in = '0; bus.burst_last = 1'b0;
    m_len = 8'd0; m_rx_cnt = 8'd0; m_rx_done = 1'b0; m_busy = 1'b0;
    for (int k = 0; k < 256; k++) m_buf[k] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_idle", bus.idle, 1);
    checkOutput("rst_db_valid", bus.db_valid, 0);
    checkOutput("rst_db_ready", bus.db_ready, 0);
    checkOutput("rst_prdata", bus.prdata, 0);
    checkOutput("rst_db_length", bus.db_length, 0);
    checkOutput("rst_last", bus.last, 0);
    checkOutput("rst_plsverr", bus.plsverr, 0);
    checkOutput("rst_apb_rd_done", bus.apb_rd_done, 0);
    checkOutput("rst_data_burst_out", bus.data_burst_out, 0);
    rst_n = 1'b1;

    $display("[TB] preloading buffer");
    for (int a = 0; a < 256; a++) applyStimulus(1'b1, 9'(a), 8'($urandom));

    applyStimulus(1'b1, 9'h003, 8'hA5);
    applyStimulus(1'b0, 9'h003, 8'h00);

    $display("[TB] stalled TX burst");
    applyStimulus(1'b1, 9'h000, 8'h11);
    applyStimulus(1'b1, 9'h001, 8'h22);
    applyStimulus(1'b1, 9'h002, 8'h33);
    applyStimulus(1'b1, 9'h100, 8'd3);
    applyStimulus(1'b1, 9'h101, 8'h01);
    bus.burst_ready = 1'b0;
    repeat (2) begin
      checkOutput("tx_stall_data", bus.data_burst_out, 8'h11);
      checkOutput("tx_stall_valid", bus.db_valid, 1);
      @(posedge clk); #1;
    end
    runTx(1'b0);

    $display("[TB] RX burst");
    rx_bytes = '{8'h7E, 8'h7F};
    applyStimulus(1'b1, 9'h101, 8'h02);
    runRx();
    applyStimulus(1'b0, 9'h103, 8'h00);
    applyStimulus(1'b0, 9'h102, 8'h00);
    applyStimulus(1'b0, 9'h000, 8'h00);
    applyStimulus(1'b0, 9'h001, 8'h00);

    $display("[TB] illegal accesses during TX");
    applyStimulus(1'b1, 9'h101, 8'h01);
    applyStimulus(1'b1, 9'h000, 8'hEE);
    applyStimulus(1'b0, 9'h1FF, 8'h00);
    applyStimulus(1'b0, 9'h102, 8'h00);
    runTx(1'b1);
    applyStimulus(1'b0, 9'h000, 8'h00);

    $display("[TB] reset during TX");
    applyStimulus(1'b1, 9'h100, 8'd6);
    applyStimulus(1'b1, 9'h101, 8'h01);
    bus.burst_ready = 1'b1;
    guard = 0;
    while (beat_q.size() > 4 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.burst_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_db_valid", bus.db_valid, 0);
    checkOutput("midrst_idle", bus.idle, 1);
    checkOutput("midrst_db_length", bus.db_length, 0);
    checkOutput("midrst_last", bus.last, 0);
    beat_q.delete();
    m_len = 8'd0; m_rx_cnt = 8'd0; m_rx_done = 1'b0; m_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 9'h102, 8'h00);
    applyStimulus(1'b0, 9'h103, 8'h00);
    applyStimulus(1'b1, 9'h100, 8'd3);
    applyStimulus(1'b1, 9'h101, 8'h01);
    runTx(1'b1);

    $display("[TB] boundary accesses");
    applyStimulus(1'b1, 9'h100, 8'd0);
    applyStimulus(1'b1, 9'h101, 8'h01);
    applyStimulus(1'b1, 9'h101, 8'h03);
    applyStimulus(1'b1, 9'h101, 8'h00);
    applyStimulus(1'b1, 9'h102, 8'h05);
    applyStimulus(1'b1, 9'h103, 8'h05);
    applyStimulus(1'b0, 9'h104, 8'h00);
    applyStimulus(1'b0, 9'h101, 8'h00);
    applyStimulus(1'b1, 9'h100, 8'd1);
    applyStimulus(1'b1, 9'h101, 8'h01);
    runTx(1'b1);

    $display("[TB] random traffic");
    for (int it = 0; it < 60; it++) begin
      int         op, n;
      logic [8:0] a;
      bit         w;
      op = $urandom_range(0, 5);
      case (op)
        0: applyStimulus(1'b1, {1'b0, 8'($urandom)}, 8'($urandom));
        1: applyStimulus(1'b0, {1'b0, 8'($urandom)}, 8'h00);
        2: begin
          a = 9'h100 + 9'($urandom_range(0, 7));
          w = 1'($urandom_range(0, 1));
          if (a == 9'h101) w = 1'b0;
          applyStimulus(w, a, 8'($urandom));
        end
        3: applyStimulus(1'($urandom_range(0, 1)), 9'h104 + 9'($urandom_range(0, 251)), 8'($urandom));
        4: begin
          applyStimulus(1'b1, 9'h100, 8'($urandom_range(0, 10)));
          applyStimulus(1'b1, 9'h101, 8'h01);
          if (m_busy) runTx(1'b1);
        end
        default: begin
          rx_bytes.delete();
          n = $urandom_range(1, 10);
          for (int k = 0; k < n; k++) rx_bytes.push_back(8'($urandom));
          applyStimulus(1'b1, 9'h101, 8'h02);
          runRx();
          applyStimulus(1'b0, 9'h103, 8'h00);
          applyStimulus(1'b0, 9'h102, 8'h00);
        end
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("apb_queue_drained", apb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/apb_burst_modport.md
Name: apb_burst_modport

Overview:
APB-slave-to-byte-burst bridge.
- An APB master fills an internal byte buffer and programs a length, then starts a TX burst streamed out on a valid/ready burst port.
- Alternatively, it starts an RX burst that captures an incoming valid/ready stream into the buffer for APB readback.
- Sits between the APB register bus and a byte-wide streaming peer.

Parameters:
DATA_W, 8, APB data and burst byte width (fixed 8).
ADDR_W, 9, APB address width; paddr[8] selects buffer (0) or registers (1).
BUF_DEPTH, 256, buffer depth in bytes; power of two, ≤256.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
paddr  input  9  APB address
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  1=write, 0=read
pwdata  input  8  APB write data
prdata  output  8  APB read data
plsverr  output  1  APB error, access phase only
apb_rd_done  output  1  successful read completed
idle  output  1  no burst in progress
burst_valid  input  1  RX: peer byte valid
burst_ready  input  1  TX: peer accepts byte
data_burst_in  input  8  RX byte
burst_last  input  1  RX final byte marker
data_burst_out  output  8  TX byte
db_length  output  8  programmed LEN register
last  output  1  TX final beat
db_ready  output  1  RX: bridge accepts byte
db_valid  output  1  TX: byte valid

Behaviour:
- Single clock clk. Asynchronous active-low reset rst_n. All registers clear on rst_n low regardless of clk.
- Reset values:
  - prdata, plsverr, apb_rd_done, data_burst_out, db_length, last, db_ready, db_valid = 0.
  - idle = 1.
  - LEN = 0, rx_done = 0, RX_CNT = 0, state = IDLE.
  - Buffer contents are not reset.
- APB: no wait states; every access completes in its access phase (psel&&penable).
- Address map:
  - 0x000–0x0FF: buffer byte paddr[7:0], R/W.
  - 0x100: LEN, R/W.
  - 0x101: CTRL, W; bit0 = start TX, bit1 = start RX.
  - 0x102: STATUS, R; bit0 = idle, bit1 = rx_done.
  - 0x103: RX_CNT, R.
- Timing: prdata is combinational from the address during the access phase, 0 otherwise. apb_rd_done = access phase && !pwrite && !plsverr.
- plsverr is high only in the access phase, for any of:
  - unmapped address (0x104–0x1FF, or buffer index ≥ BUF_DEPTH);
  - any buffer or LEN/CTRL access while !idle;
  - CTRL with both bits set;
  - TX start with LEN=0;
  - write to STATUS or RX_CNT.
  - An erroring write has no effect.
- FSM states IDLE, TX, RX. idle = (state==IDLE). db_length = LEN at all times.
- IDLE → TX on CTRL bit0 write: clears index, clears rx_done.
- In TX:
  - db_valid=1; data_burst_out=buf[idx]; last=(idx==LEN-1).
  - A beat transfers when db_valid&&burst_ready; idx then increments.
  - data_burst_out holds stable while burst_ready=0.
  - After the last beat transfers, next state is IDLE and db_valid, last drop.
- IDLE → RX on CTRL bit1 write: clears index and rx_done.
- In RX:
  - db_ready=1. Each burst_valid&&db_ready writes data_burst_in to buf[idx]; idx increments.
  - On a transfer with burst_last=1, or at idx==BUF_DEPTH-1: RX_CNT=idx+1, rx_done=1, state → IDLE, db_ready drops next cycle.
- burst_valid or burst_ready outside the matching state is ignored.
- Reset mid-burst aborts immediately; the next start begins at index 0.
- No output is ever X after reset.

Optional Feature:
APB_BURST_ERR_EN.
- Defined: plsverr generated as above.
- Not defined: plsverr tied 0. Illegal accesses are still ignored, reads return 0, and apb_rd_done asserts for every read access phase.

Decomposition:
Package apb_burst_pkg holds:
- register offsets (0x100–0x103);
- CTRL/STATUS bit positions;
- state enum {IDLE, TX, RX}.

Sub-module apb_burst_buf: BUF_DEPTH×8 RAM with one write port (APB or RX, muxed) and an asynchronous read port (APB or TX).

Test Plan:
- Reset → idle=1, db_valid=0, db_ready=0, prdata=0, db_length=0; no X on any output.
- APB write 0xA5 to 0x003, read 0x003 → prdata=0xA5, apb_rd_done=1 in the access phase, plsverr=0.
- Load 0x11,0x22,0x33 at 0x000–0x002; LEN=3; CTRL=0x01; hold burst_ready=0 for 2 cycles then 1 → data_burst_out holds 0x11 while stalled; then 0x11,0x22,0x33 with last only on 0x33; idle=1 after.
- CTRL=0x02; send 0x7E,0x7F with burst_last on 0x7F → RX_CNT=2, STATUS=0x03, buffer[0..1]=0x7E,0x7F.
- During TX, write 0x000 → plsverr=1, buffer unchanged. Read 0x1FF → plsverr=1, apb_rd_done=0.
- Assert rst_n low mid-TX → db_valid=0 and idle=1 asynchronously; the restarted burst sends buffer[0] first.
